// File: rtl/pmem_responder_if.sv
// Physical-memory line bus between the cache (master) and the memory-side
// responder (slave). One 128-bit line per transfer, 16-bit byte address.
interface pmem_responder_if;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;
  logic         pmem_error;

  // Cache side: issues requests, consumes the response.
  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata, pmem_error
  );

  // Memory side: accepts requests, produces the response.
  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata, pmem_error
  );
endinterface

// File: rtl/pmem_responder.sv
// Fixed-latency physical-memory responder backed by a small register-array
// line store. Accepts one line read or write at a time, answers with a
// one-cycle pmem_resp pulse LATENCY cycles after acceptance, then idles one
// GAP cycle so the cache has time to drop its request.
module pmem_responder #(
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned DEPTH_LINES = 16
) (
  input  logic              clk,
  input  logic              reset,
  pmem_responder_if.slave   pmem
);

  localparam int unsigned IDXW     = $clog2(DEPTH_LINES);
  localparam logic [7:0]  CNT_LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_GAP
  } state_t;

  state_t          r_state;
  logic [7:0]      r_cnt;
  logic            r_op_wr;
  logic [IDXW-1:0] r_idx;
  logic [127:0]    r_wdata;
  logic            r_resp;
  logic            r_error;
  logic [127:0]    r_rdata;
  logic [127:0]    r_store [DEPTH_LINES];

  logic            w_req_one;
  logic            w_req_both;
  logic            w_op_held;
  logic [IDXW-1:0] w_idx_in;
  logic            w_accept;
  logic            w_fire_now;
  logic            w_fire_wait;
  logic            w_fire;
  logic            w_fire_wr;
  logic [IDXW-1:0] w_fire_idx;
  logic [127:0]    w_fire_data;
  logic            w_unused;

  // Request decode and the "entering RESP" strobe with its operands. With
  // LATENCY=1 the access happens straight out of IDLE, so the live bus
  // values are used instead of the (not yet loaded) latches.
  always_comb begin
    w_req_one   = pmem.pmem_read ^ pmem.pmem_write;
    w_req_both  = pmem.pmem_read & pmem.pmem_write;
    w_op_held   = r_op_wr ? pmem.pmem_write : pmem.pmem_read;
    w_idx_in    = pmem.pmem_address[4 +: IDXW];
    w_accept    = (r_state == S_IDLE) && w_req_one;
    w_fire_now  = w_accept && (CNT_LOAD == 8'd0);
    w_fire_wait = (r_state == S_WAIT) && w_op_held && (r_cnt == 8'd1);
    w_fire      = w_fire_now | w_fire_wait;
    w_fire_wr   = w_fire_now ? pmem.pmem_write : r_op_wr;
    w_fire_idx  = w_fire_now ? w_idx_in        : r_idx;
    w_fire_data = w_fire_now ? pmem.pmem_wdata : r_wdata;
  end

  // Offset and aliased upper address bits are intentionally dropped.
  assign w_unused = ^pmem.pmem_address;

  // Control FSM: state, latency counter, response pulse, sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_op_wr <= 1'b0;
      r_resp  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_resp <= w_fire;
      case (r_state)
        S_IDLE: begin
          if (w_req_both) begin
            r_error <= 1'b1;
          end else if (w_req_one) begin
            r_op_wr <= pmem.pmem_write;
            r_cnt   <= CNT_LOAD;
            r_state <= (CNT_LOAD == 8'd0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!w_op_held) begin
            r_cnt   <= 8'd0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
            if (r_cnt == 8'd1) r_state <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_GAP;
        S_GAP:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Request operand latch; only meaningful while an operation is pending.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_idx   <= w_idx_in;
      r_wdata <= pmem.pmem_wdata;
    end
  end

  // Line store and registered read data, both updated on entry to RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
      for (int i = 0; i < int'(DEPTH_LINES); i++) r_store[i] <= '0;
    end else if (w_fire) begin
      if (w_fire_wr) r_store[w_fire_idx] <= w_fire_data;
      else           r_rdata <= r_store[w_fire_idx];
    end
  end

  assign pmem.pmem_resp  = r_resp;
  assign pmem.pmem_rdata = r_rdata;
  assign pmem.pmem_error = r_error;

endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: a driver issues line requests and
// pushes the expected response (cycle and data) from a reference line array;
// a monitor pops and compares whenever pmem_resp is seen.
module tb_pmem_responder;

  localparam int LAT   = 4;
  localparam int DEPTH = 16;

  typedef struct {
    bit           chk_data;
    logic [127:0] data;
    int           cyc;
  } sb_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   nvec = 0;
  int   nerr = 0;
  int   free_cyc = 0;
  sb_t  sbq[$];
  logic [127:0] model [DEPTH];

  pmem_responder_if bus();

  pmem_responder #(.LATENCY(LAT), .DEPTH_LINES(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .pmem  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int line_of(input logic [15:0] a);
    return (int'(a) / 16) % DEPTH;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    sb_t e;
    forever begin
      @(negedge clk);
      if (bus.pmem_resp === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_resp", 128'd1, 128'd0);
        end else begin
          e = sbq.pop_front();
          chk("resp_cycle", 128'(cyc), 128'(e.cyc));
          if (e.chk_data) chk("rdata", bus.pmem_rdata, e.data);
        end
      end
    end
  endtask

  task automatic idle_bus();
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_free();
    while (cyc < free_cyc) step();
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    idle_bus();
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_model();
    free_cyc = cyc;
  endtask

  // Complete transaction; called at posedge+1, returns at posedge+1 of the
  // cycle after the response (request dropped there).
  task automatic txn(input bit wr, input logic [15:0] a, input logic [127:0] d);
    sb_t e;
    int  acc;
    bit  got;
    acc        = (cyc > free_cyc) ? cyc : free_cyc;
    e.cyc      = acc + LAT;
    e.chk_data = !wr;
    e.data     = model[line_of(a)];
    if (wr) model[line_of(a)] = d;
    sbq.push_back(e);
    free_cyc = acc + LAT + 2;
    bus.pmem_address = a;
    bus.pmem_wdata   = d;
    bus.pmem_read    = !wr;
    bus.pmem_write   = wr;
    got = 1'b0;
    for (int i = 0; i < LAT + 8 && !got; i++) begin
      @(negedge clk);
      if (bus.pmem_resp === 1'b1) got = 1'b1;
    end
    if (!got) chk("resp_timeout", 128'd0, 128'd1);
    step();
    idle_bus();
  endtask

  // Request dropped after dly WAIT cycles: no response, no store change.
  task automatic abort_txn(input bit wr, input logic [15:0] a, input logic [127:0] d, input int dly);
    int acc;
    acc = (cyc > free_cyc) ? cyc : free_cyc;
    bus.pmem_address = a;
    bus.pmem_wdata   = d;
    bus.pmem_read    = !wr;
    bus.pmem_write   = wr;
    while (cyc < acc + dly) step();
    idle_bus();
    free_cyc = cyc + 1;
    step();
  endtask

  initial begin
    int  k;
    int  nresp;
    bit  wr;
    int  gap;
    logic [15:0]  a;
    logic [127:0] d;

    reset = 1'b1;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    idle_bus();
    clear_model();
    fork monitor(); join_none

    // Reset state
    step();
    do_reset(2);
    @(negedge clk);
    chk("reset_resp",  128'(bus.pmem_resp),  128'd0);
    chk("reset_rdata", bus.pmem_rdata,       128'd0);
    chk("reset_error", 128'(bus.pmem_error), 128'd0);
    step();

    // Read after reset, write/read-back, other line, aliasing
    txn(1'b0, 16'h0040, '0);
    txn(1'b1, 16'h0050, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    txn(1'b0, 16'h0057, '0);
    txn(1'b0, 16'h0060, '0);
    txn(1'b1, 16'h0100, {16{8'hA5}});
    txn(1'b0, 16'h0000, '0);

    // Back-to-back: read held high across two transactions
    wait_free();
    k = cyc;
    sbq.push_back('{chk_data: 1'b1, data: model[line_of(16'h0050)], cyc: k + LAT});
    sbq.push_back('{chk_data: 1'b1, data: model[line_of(16'h0050)], cyc: k + 2*LAT + 2});
    free_cyc = k + 2*LAT + 4;
    bus.pmem_address = 16'h0050;
    bus.pmem_read    = 1'b1;
    nresp = 0;
    for (int i = 0; i < 2*LAT + 12 && nresp < 2; i++) begin
      @(negedge clk);
      if (bus.pmem_resp === 1'b1) nresp++;
    end
    chk("b2b_resp_count", 128'(nresp), 128'd2);
    step();
    idle_bus();

    // Abort a write mid-WAIT: prior contents survive
    txn(1'b1, 16'h0020, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    wait_free();
    abort_txn(1'b1, 16'h0020, 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF, 2);
    txn(1'b0, 16'h0020, '0);

    // Protocol error: both requests for one IDLE cycle
    wait_free();
    bus.pmem_address = 16'h0050;
    bus.pmem_wdata   = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
    bus.pmem_read    = 1'b1;
    bus.pmem_write   = 1'b1;
    step();
    idle_bus();
    free_cyc = cyc;
    @(negedge clk);
    chk("error_set", 128'(bus.pmem_error), 128'd1);
    step();
    txn(1'b0, 16'h0050, '0);
    txn(1'b1, 16'h0030, 128'h5);
    txn(1'b0, 16'h0030, '0);
    @(negedge clk);
    chk("error_sticky", 128'(bus.pmem_error), 128'd1);
    step();

    // Reset two cycles into a read
    wait_free();
    k = cyc;
    bus.pmem_address = 16'h0050;
    bus.pmem_read    = 1'b1;
    while (cyc < k + 2) step();
    reset = 1'b1;
    idle_bus();
    step();
    reset = 1'b0;
    clear_model();
    free_cyc = cyc;
    @(negedge clk);
    chk("midrst_resp",  128'(bus.pmem_resp),  128'd0);
    chk("midrst_rdata", bus.pmem_rdata,       128'd0);
    chk("midrst_error", 128'(bus.pmem_error), 128'd0);
    step();
    txn(1'b0, 16'h0050, '0);

    // Randomized traffic
    for (int t = 0; t < 80; t++) begin
      wr  = 1'($urandom_range(0, 1));
      a   = 16'($urandom);
      d   = rand128();
      gap = $urandom_range(0, 2);
      repeat (gap) step();
      if ($urandom_range(0, 9) == 0) abort_txn(wr, a, d, $urandom_range(1, LAT - 1));
      else                           txn(wr, a, d);
    end

    repeat (LAT + 4) step();
    chk("scoreboard_drained", 128'(sbq.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
